// File: rtl/rt_responder.sv
// MIL-STD-1553 style remote terminal responder: command decode, receive/transmit data, status reply.
// Optional broadcast reception is enabled by defining RT_BROADCAST_EN.
module rt_responder #(
    parameter int RESP_GAP     = 16,
    parameter int WORD_TIMEOUT = 64
) (
    input  logic        clk_out,
    input  logic        reset_slow,
    input  logic [4:0]  rt_addr,
    input  logic [15:0] rx_dword,
    input  logic        rx_dval,
    input  logic        rx_csw,
    input  logic        rx_dw,
    input  logic        rx_perr,
    input  logic        tx_busy,
    output logic [15:0] tx_dword,
    output logic        tx_csw,
    output logic        tx_dw,
    output logic [9:0]  buf_addr,
    output logic        buf_we,
    output logic [15:0] buf_wdata,
    input  logic [15:0] buf_rdata,
    output logic        msg_done,
    output logic        msg_err
);

    localparam int MAXP = (RESP_GAP > WORD_TIMEOUT) ? RESP_GAP : WORD_TIMEOUT;
    localparam int CW   = $clog2(MAXP + 1);

    typedef enum logic [2:0] {IDLE, RX_DATA, GAP, TX_STAT, TX_DATA, WAIT_TX} state_t;

    state_t        state, state_nxt;
    logic          cmd_tr, cmd_tr_nxt;
    logic [4:0]    cmd_sa, cmd_sa_nxt;
    logic [4:0]    cmd_cnt, cmd_cnt_nxt;
    logic [4:0]    word_idx, word_idx_nxt;
    logic [CW-1:0] cyc_cnt, cyc_cnt_nxt;
    logic [1:0]    tx_phase, tx_phase_nxt;
    logic          busy_seen, busy_seen_nxt;
    logic          data_inflight, data_inflight_nxt;
    logic          bcast_msg, bcast_msg_nxt;
    logic          bcast_flag, bcast_flag_nxt;
    logic [15:0]   tx_hold, tx_hold_nxt;
    logic [15:0]   tx_dword_nxt;
    logic          tx_csw_nxt, tx_dw_nxt;
    logic [9:0]    buf_addr_nxt;
    logic          buf_we_nxt;
    logic [15:0]   buf_wdata_nxt;
    logic          msg_done_nxt, msg_err_nxt;

    logic own_match, bcast_match, cmd_ok, cmd_mode, cur_mode, last_word;

    assign own_match = (rx_dword[15:11] == rt_addr);
`ifdef RT_BROADCAST_EN
    assign bcast_match = (rx_dword[15:11] == 5'd31) && !own_match && !rx_dword[10];
`else
    assign bcast_match = 1'b0;
`endif
    assign cmd_ok    = rx_dval && rx_csw && !rx_perr && (own_match || bcast_match);
    assign cmd_mode  = (rx_dword[9:5] == 5'd0) || (rx_dword[9:5] == 5'd31);
    assign cur_mode  = (cmd_sa == 5'd0) || (cmd_sa == 5'd31);
    // A word count of 0 encodes 32, so the 5-bit subtraction wraps to 31 as intended.
    assign last_word = (word_idx == (cmd_cnt - 5'd1));

    always_ff @(posedge clk_out or posedge reset_slow) begin
        if (reset_slow) begin
            state         <= IDLE;
            cmd_tr        <= 1'b0;
            cmd_sa        <= '0;
            cmd_cnt       <= '0;
            word_idx      <= '0;
            cyc_cnt       <= '0;
            tx_phase      <= '0;
            busy_seen     <= 1'b0;
            data_inflight <= 1'b0;
            bcast_msg     <= 1'b0;
            bcast_flag    <= 1'b0;
            tx_hold       <= '0;
            tx_dword      <= '0;
            tx_csw        <= 1'b0;
            tx_dw         <= 1'b0;
            buf_addr      <= '0;
            buf_we        <= 1'b0;
            buf_wdata     <= '0;
            msg_done      <= 1'b0;
            msg_err       <= 1'b0;
        end else begin
            state         <= state_nxt;
            cmd_tr        <= cmd_tr_nxt;
            cmd_sa        <= cmd_sa_nxt;
            cmd_cnt       <= cmd_cnt_nxt;
            word_idx      <= word_idx_nxt;
            cyc_cnt       <= cyc_cnt_nxt;
            tx_phase      <= tx_phase_nxt;
            busy_seen     <= busy_seen_nxt;
            data_inflight <= data_inflight_nxt;
            bcast_msg     <= bcast_msg_nxt;
            bcast_flag    <= bcast_flag_nxt;
            tx_hold       <= tx_hold_nxt;
            tx_dword      <= tx_dword_nxt;
            tx_csw        <= tx_csw_nxt;
            tx_dw         <= tx_dw_nxt;
            buf_addr      <= buf_addr_nxt;
            buf_we        <= buf_we_nxt;
            buf_wdata     <= buf_wdata_nxt;
            msg_done      <= msg_done_nxt;
            msg_err       <= msg_err_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        cmd_tr_nxt        = cmd_tr;
        cmd_sa_nxt        = cmd_sa;
        cmd_cnt_nxt       = cmd_cnt;
        word_idx_nxt      = word_idx;
        cyc_cnt_nxt       = cyc_cnt;
        tx_phase_nxt      = tx_phase;
        busy_seen_nxt     = busy_seen;
        data_inflight_nxt = data_inflight;
        bcast_msg_nxt     = bcast_msg;
        bcast_flag_nxt    = bcast_flag;
        tx_hold_nxt       = tx_hold;
        tx_dword_nxt      = tx_dword;
        tx_csw_nxt        = 1'b0;
        tx_dw_nxt         = 1'b0;
        buf_addr_nxt      = buf_addr;
        buf_we_nxt        = 1'b0;
        buf_wdata_nxt     = buf_wdata;
        msg_done_nxt      = 1'b0;
        msg_err_nxt       = msg_err;

        // A valid command is accepted in every state; outside IDLE it supersedes the current message.
        if (cmd_ok) begin
            cmd_tr_nxt        = rx_dword[10];
            cmd_sa_nxt        = rx_dword[9:5];
            cmd_cnt_nxt       = rx_dword[4:0];
            word_idx_nxt      = '0;
            cyc_cnt_nxt       = '0;
            tx_phase_nxt      = '0;
            busy_seen_nxt     = 1'b0;
            data_inflight_nxt = 1'b0;
            msg_err_nxt       = 1'b0;
            bcast_msg_nxt     = bcast_match;
            if (bcast_match && cmd_mode) begin
                bcast_flag_nxt = 1'b1;
                msg_done_nxt   = 1'b1;
                state_nxt      = IDLE;
            end else if (!rx_dword[10] && !cmd_mode) begin
                state_nxt = RX_DATA;
            end else begin
                state_nxt = GAP;
            end
        end else begin
            case (state)
                IDLE: begin
                end
                RX_DATA: begin
                    if (rx_dval && rx_dw && !rx_perr) begin
                        buf_we_nxt    = 1'b1;
                        buf_addr_nxt  = {cmd_sa, word_idx};
                        buf_wdata_nxt = rx_dword;
                        word_idx_nxt  = word_idx + 5'd1;
                        cyc_cnt_nxt   = '0;
                        if (last_word) begin
                            if (bcast_msg) begin
                                bcast_flag_nxt = 1'b1;
                                msg_done_nxt   = 1'b1;
                                state_nxt      = IDLE;
                            end else begin
                                state_nxt = GAP;
                            end
                        end
                    end else if ((rx_dval && (rx_perr || rx_csw)) ||
                                 (cyc_cnt == CW'(WORD_TIMEOUT))) begin
                        msg_err_nxt  = 1'b1;
                        msg_done_nxt = 1'b1;
                        state_nxt    = IDLE;
                    end else begin
                        cyc_cnt_nxt = cyc_cnt + CW'(1);
                    end
                end
                GAP: begin
                    if (cyc_cnt == CW'(RESP_GAP - 1)) begin
                        cyc_cnt_nxt = '0;
                        state_nxt   = TX_STAT;
                    end else begin
                        cyc_cnt_nxt = cyc_cnt + CW'(1);
                    end
                end
                TX_STAT: begin
                    if (!tx_busy) begin
                        tx_dword_nxt      = {rt_addr, msg_err, 5'b0, bcast_flag, 4'b0};
                        tx_csw_nxt        = 1'b1;
                        bcast_flag_nxt    = 1'b0;
                        busy_seen_nxt     = 1'b0;
                        data_inflight_nxt = 1'b0;
                        state_nxt         = WAIT_TX;
                    end
                end
                TX_DATA: begin
                    // Phases: present address, let the buffer respond, capture, then send.
                    case (tx_phase)
                        2'd0: begin
                            buf_addr_nxt = {cmd_sa, word_idx};
                            tx_phase_nxt = 2'd1;
                        end
                        2'd1: tx_phase_nxt = 2'd2;
                        2'd2: begin
                            tx_hold_nxt  = buf_rdata;
                            tx_phase_nxt = 2'd3;
                        end
                        default: begin
                            if (!tx_busy) begin
                                tx_dword_nxt      = tx_hold;
                                tx_dw_nxt         = 1'b1;
                                busy_seen_nxt     = 1'b0;
                                data_inflight_nxt = 1'b1;
                                state_nxt         = WAIT_TX;
                            end
                        end
                    endcase
                end
                WAIT_TX: begin
                    if (!busy_seen) begin
                        if (tx_busy) begin
                            busy_seen_nxt = 1'b1;
                        end
                    end else if (!tx_busy) begin
                        busy_seen_nxt = 1'b0;
                        if (data_inflight && !last_word) begin
                            word_idx_nxt = word_idx + 5'd1;
                            tx_phase_nxt = 2'd0;
                            state_nxt    = TX_DATA;
                        end else if (!data_inflight && cmd_tr && !cur_mode) begin
                            word_idx_nxt = '0;
                            tx_phase_nxt = 2'd0;
                            state_nxt    = TX_DATA;
                        end else begin
                            msg_done_nxt = 1'b1;
                            state_nxt    = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rt_responder.sv
// Directed self-checking bench for rt_responder with an encoder busy model and a buffer RAM model.
`timescale 1ns/1ps
module tb_rt_responder;

    localparam int RESP_GAP     = 16;
    localparam int WORD_TIMEOUT = 64;

    logic        clk_out    = 1'b0;
    logic        reset_slow = 1'b0;
    logic [4:0]  rt_addr    = 5'd5;
    logic [15:0] rx_dword   = '0;
    logic        rx_dval    = 1'b0;
    logic        rx_csw     = 1'b0;
    logic        rx_dw      = 1'b0;
    logic        rx_perr    = 1'b0;
    logic        tx_busy    = 1'b0;
    logic [15:0] tx_dword;
    logic        tx_csw;
    logic        tx_dw;
    logic [9:0]  buf_addr;
    logic        buf_we;
    logic [15:0] buf_wdata;
    logic [15:0] buf_rdata;
    logic        msg_done;
    logic        msg_err;

    logic        pre_we   = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;
    logic [15:0] mem [0:1023];

    logic [16:0] tx_log [$];
    logic [25:0] we_log [$];
    int          done_cnt    = 0;
    int          overlap_cnt = 0;
    int          busy_left   = 0;
    int          n_cmp  = 0;
    int          n_fail = 0;

    rt_responder #(.RESP_GAP(RESP_GAP), .WORD_TIMEOUT(WORD_TIMEOUT)) dut (
        .clk_out(clk_out), .reset_slow(reset_slow), .rt_addr(rt_addr),
        .rx_dword(rx_dword), .rx_dval(rx_dval), .rx_csw(rx_csw), .rx_dw(rx_dw),
        .rx_perr(rx_perr), .tx_busy(tx_busy), .tx_dword(tx_dword), .tx_csw(tx_csw),
        .tx_dw(tx_dw), .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdata(buf_wdata),
        .buf_rdata(buf_rdata), .msg_done(msg_done), .msg_err(msg_err)
    );

    always #5 clk_out = ~clk_out;

    always @(posedge clk_out) begin
        if (buf_we) mem[buf_addr] <= buf_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
        buf_rdata <= mem[buf_addr];
    end

    // Encoder model stays busy for three cycles per request; the monitor logs every pulse.
    initial forever begin
        @(negedge clk_out);
        if (tx_csw || tx_dw) begin
            if (tx_busy) overlap_cnt++;
            tx_log.push_back({tx_csw, tx_dword});
            busy_left = 3;
            tx_busy   = 1'b1;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
        end
        if (buf_we) we_log.push_back({buf_addr, buf_wdata});
        if (msg_done) done_cnt++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] w, input logic csw, input logic perr);
        @(negedge clk_out);
        rx_dword = w;
        rx_csw   = csw;
        rx_dw    = !csw;
        rx_perr  = perr;
        rx_dval  = 1'b1;
        @(negedge clk_out);
        rx_dval  = 1'b0;
        rx_csw   = 1'b0;
        rx_dw    = 1'b0;
        rx_perr  = 1'b0;
    endtask

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        @(negedge clk_out);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk_out);
        pre_we   = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk_out);
    endtask

    task automatic waitCsw(input int bound, output int cycles);
        cycles = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk_out);
            if (tx_csw) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic waitDone(input int base, input int bound, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_out);
            if (done_cnt > base) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [16:0] getTx(input int i);
        if (i < 0 || i >= tx_log.size()) return 17'h1FFFF;
        return tx_log[i];
    endfunction

    function automatic logic [25:0] getWe(input int i);
        if (i < 0 || i >= we_log.size()) return 26'h3FFFFFF;
        return we_log[i];
    endfunction

    initial begin
        int   tb, wb, db, cyc;
        logic seen;

        #2 reset_slow = 1'b1;
        idleCycles(3);
        checkOutput("reset_outputs",
                    {tx_dword, tx_csw, tx_dw, buf_addr, buf_we, buf_wdata, msg_done, msg_err}, 48'h0);
        reset_slow = 1'b0;
        idleCycles(3);

        $display("[TB] receive two words into SA1");
        tb = tx_log.size(); wb = we_log.size(); db = done_cnt;
        applyStimulus(16'h2822, 1'b1, 1'b0);
        applyStimulus(16'h1234, 1'b0, 1'b0);
        applyStimulus(16'hABCD, 1'b0, 1'b0);
        waitCsw(60, cyc);
        checkOutput("rx_gap_timing", 48'(cyc >= RESP_GAP && cyc <= RESP_GAP + 2), 48'h1);
        checkOutput("rx_status", 48'(tx_dword), 48'h2800);
        waitDone(db, 60, seen);
        checkOutput("rx_done", 48'(seen), 48'h1);
        checkOutput("rx_we_count", 48'(we_log.size() - wb), 48'd2);
        checkOutput("rx_we0", 48'(getWe(wb)), {22'h0, 10'h020, 16'h1234});
        checkOutput("rx_we1", 48'(getWe(wb + 1)), {22'h0, 10'h021, 16'hABCD});
        checkOutput("rx_tx_count", 48'(tx_log.size() - tb), 48'd1);

        $display("[TB] transmit three words from SA2");
        preload(10'h040, 16'h0001);
        preload(10'h041, 16'h0002);
        preload(10'h042, 16'h0003);
        tb = tx_log.size(); db = done_cnt;
        applyStimulus(16'h2C43, 1'b1, 1'b0);
        waitDone(db, 300, seen);
        checkOutput("tx_done", 48'(seen), 48'h1);
        checkOutput("tx_count", 48'(tx_log.size() - tb), 48'd4);
        checkOutput("tx_stat", 48'(getTx(tb)), {31'h0, 1'b1, 16'h2800});
        checkOutput("tx_d0", 48'(getTx(tb + 1)), {31'h0, 1'b0, 16'h0001});
        checkOutput("tx_d1", 48'(getTx(tb + 2)), {31'h0, 1'b0, 16'h0002});
        checkOutput("tx_d2", 48'(getTx(tb + 3)), {31'h0, 1'b0, 16'h0003});
        checkOutput("tx_overlap", 48'(overlap_cnt), 48'd0);

        $display("[TB] parity error on second data word");
        tb = tx_log.size(); wb = we_log.size(); db = done_cnt;
        applyStimulus(16'h2822, 1'b1, 1'b0);
        applyStimulus(16'h1111, 1'b0, 1'b0);
        applyStimulus(16'h2222, 1'b0, 1'b1);
        waitDone(db, 10, seen);
        checkOutput("perr_done", 48'(seen), 48'h1);
        checkOutput("perr_msg_err", 48'(msg_err), 48'h1);
        idleCycles(40);
        checkOutput("perr_no_status", 48'(tx_log.size() - tb), 48'd0);
        checkOutput("perr_we_count", 48'(we_log.size() - wb), 48'd1);
        applyStimulus(16'h2821, 1'b1, 1'b0);
        checkOutput("perr_err_cleared", 48'(msg_err), 48'h0);
        applyStimulus(16'h5555, 1'b0, 1'b0);
        waitCsw(60, cyc);
        checkOutput("perr_next_status", 48'(tx_dword), 48'h2800);
        idleCycles(20);

        $display("[TB] command to another terminal");
        tb = tx_log.size(); wb = we_log.size(); db = done_cnt;
        applyStimulus(16'h3022, 1'b1, 1'b0);
        applyStimulus(16'h0001, 1'b0, 1'b0);
        applyStimulus(16'h0002, 1'b0, 1'b0);
        idleCycles(60);
        checkOutput("other_we", 48'(we_log.size() - wb), 48'd0);
        checkOutput("other_tx", 48'(tx_log.size() - tb), 48'd0);
        checkOutput("other_done", 48'(done_cnt - db), 48'd0);

        $display("[TB] data word timeout");
        tb = tx_log.size();
        applyStimulus(16'h2822, 1'b1, 1'b0);
        applyStimulus(16'h7777, 1'b0, 1'b0);
        cyc = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk_out);
            if (msg_done) begin
                cyc = i;
                break;
            end
        end
        checkOutput("timeout_timing", 48'(cyc >= WORD_TIMEOUT && cyc <= WORD_TIMEOUT + 3), 48'h1);
        checkOutput("timeout_msg_err", 48'(msg_err), 48'h1);
        idleCycles(30);
        checkOutput("timeout_no_status", 48'(tx_log.size() - tb), 48'd0);

        $display("[TB] superseding command during receive");
        tb = tx_log.size(); wb = we_log.size(); db = done_cnt;
        applyStimulus(16'h2822, 1'b1, 1'b0);
        applyStimulus(16'h1357, 1'b0, 1'b0);
        applyStimulus(16'h2821, 1'b1, 1'b0);
        applyStimulus(16'h4444, 1'b0, 1'b0);
        waitCsw(60, cyc);
        checkOutput("super_status", 48'(tx_dword), 48'h2800);
        waitDone(db, 60, seen);
        checkOutput("super_done", 48'(seen), 48'h1);
        checkOutput("super_we_last", 48'(getWe(wb + 1)), {22'h0, 10'h020, 16'h4444});
        checkOutput("super_tx_count", 48'(tx_log.size() - tb), 48'd1);

        $display("[TB] transmit with word count 32");
        preload(10'h060, 16'hCAFE);
        preload(10'h07F, 16'hBEEF);
        tb = tx_log.size(); db = done_cnt;
        applyStimulus(16'h2C60, 1'b1, 1'b0);
        waitDone(db, 2000, seen);
        checkOutput("cnt32_done", 48'(seen), 48'h1);
        checkOutput("cnt32_count", 48'(tx_log.size() - tb), 48'd33);
        checkOutput("cnt32_first", 48'(getTx(tb + 1)), {31'h0, 1'b0, 16'hCAFE});
        checkOutput("cnt32_last", 48'(getTx(tb + 32)), {31'h0, 1'b0, 16'hBEEF});
        checkOutput("cnt32_overlap", 48'(overlap_cnt), 48'd0);

        $display("[TB] reset during data transmission");
        applyStimulus(16'h2C43, 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_out);
            if (tx_dw) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("rst_reached_tx_data", 48'(seen), 48'h1);
        reset_slow = 1'b1;
        #1;
        checkOutput("rst_mid_outputs",
                    {tx_dword, tx_csw, tx_dw, buf_addr, buf_we, buf_wdata, msg_done, msg_err}, 48'h0);
        idleCycles(3);
        reset_slow = 1'b0;
        idleCycles(10);
        tb = tx_log.size(); wb = we_log.size(); db = done_cnt;
        idleCycles(80);
        checkOutput("rst_quiet_tx", 48'(tx_log.size() - tb), 48'd0);
        checkOutput("rst_quiet_done", 48'(done_cnt - db), 48'd0);
        checkOutput("rst_quiet_we", 48'(we_log.size() - wb), 48'd0);

`ifdef RT_BROADCAST_EN
        $display("[TB] broadcast receive");
        tb = tx_log.size(); wb = we_log.size(); db = done_cnt;
        applyStimulus(16'hF821, 1'b1, 1'b0);
        applyStimulus(16'h9ABC, 1'b0, 1'b0);
        waitDone(db, 20, seen);
        checkOutput("bc_done", 48'(seen), 48'h1);
        checkOutput("bc_we", 48'(getWe(wb)), {22'h0, 10'h020, 16'h9ABC});
        idleCycles(40);
        checkOutput("bc_no_status", 48'(tx_log.size() - tb), 48'd0);
        db = done_cnt;
        applyStimulus(16'h2C41, 1'b1, 1'b0);
        waitCsw(60, cyc);
        checkOutput("bc_flag_status", 48'(tx_dword), 48'h2810);
        waitDone(db, 100, seen);
        db = done_cnt;
        applyStimulus(16'h2C41, 1'b1, 1'b0);
        waitCsw(60, cyc);
        checkOutput("bc_flag_cleared", 48'(tx_dword), 48'h2800);
        waitDone(db, 100, seen);
        checkOutput("bc_final_done", 48'(seen), 48'h1);
`else
        $display("[TB] address 31 without broadcast support");
        tb = tx_log.size(); wb = we_log.size(); db = done_cnt;
        applyStimulus(16'hF821, 1'b1, 1'b0);
        applyStimulus(16'h9ABC, 1'b0, 1'b0);
        idleCycles(50);
        checkOutput("nobc_we", 48'(we_log.size() - wb), 48'd0);
        checkOutput("nobc_done", 48'(done_cnt - db), 48'd0);
        checkOutput("nobc_tx", 48'(tx_log.size() - tb), 48'd0);
        tb = tx_log.size();
        applyStimulus(16'h2C41, 1'b1, 1'b0);
        waitCsw(60, cyc);
        checkOutput("nobc_status", 48'(tx_dword), 48'h2800);
        waitDone(db, 100, seen);
        checkOutput("nobc_final_done", 48'(seen), 48'h1);
        checkOutput("nobc_data", 48'(getTx(tb + 1)), {31'h0, 1'b0, 16'h0001});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rt_responder.md
RT_RESPONDER -- requirements
Module: rt_responder

Interface
REQ-001 Parameter RESP_GAP, default 16: clk_out cycles from the last accepted receive word to the status word request.
REQ-002 Parameter WORD_TIMEOUT, default 64: maximum clk_out cycles allowed between consecutive expected data words.
REQ-003 clk_out  input  1  block clock; all inputs are synchronous to it.
REQ-004 reset_slow  input  1  asynchronous, active-high reset.
REQ-005 rt_addr  input  5  own remote terminal address.
REQ-006 rx_dword  input  16  decoded word payload.
REQ-007 rx_dval  input  1  one-cycle strobe; rx_dword, rx_csw, rx_dw and rx_perr are valid.
REQ-008 rx_csw / rx_dw  input  1 each  command/status sync versus data sync of the received word.
REQ-009 rx_perr  input  1  parity error on the received word.
REQ-010 tx_busy  input  1  encoder busy.
REQ-011 tx_dword  output  16  word to encode.
REQ-012 tx_csw / tx_dw  output  1 each  one-cycle request to send tx_dword with command/status or data sync.
REQ-013 buf_addr  output  10  {subaddress[4:0], word index[4:0]} into the external subaddress buffer.
REQ-014 buf_we  output  1  write strobe.
REQ-015 buf_wdata  output  16  write data.
REQ-016 buf_rdata  input  16  read data, valid one cycle after buf_addr.
REQ-017 msg_done  output  1  one-cycle pulse at the end of every message, good or bad.
REQ-018 msg_err  output  1  sticky message-error flag; cleared by the next valid command.

Function
REQ-019 Command decode: [15:11] address, [10] T/R (1 = transmit), [9:5] subaddress, [4:0] word count; count 0 means 32; subaddress 0 or 31 is a mode code with no data words.
REQ-020 States: IDLE, RX_DATA, GAP, TX_STAT, TX_DATA, WAIT_TX.
REQ-021 IDLE -> on rx_dval, rx_csw, !rx_perr and address == rt_addr: latch the command and clear msg_err.
  - Receive command: go to RX_DATA.
  - Transmit command or mode code: go to GAP.
  - Any other word in IDLE is ignored.
REQ-022 RX_DATA:
  - Each rx_dval with rx_dw and !rx_perr writes buf_wdata = rx_dword at index n, with buf_we high for exactly one cycle, then n increments.
  - After the counted word, go to GAP.
REQ-023 RX_DATA error: a parity error, an rx_csw word, or a WORD_TIMEOUT expiry sets msg_err and returns to IDLE without a status response; msg_done pulses.
REQ-024 GAP: count RESP_GAP cycles, then go to TX_STAT.
REQ-025 TX_STAT:
  - When tx_busy == 0, drive tx_dword = status and pulse tx_csw for one cycle.
  - Then enter WAIT_TX: wait for tx_busy to rise, then fall.
REQ-026 Status word:
  - [15:11] = rt_addr.
  - [10] = msg_err.
  - [4] = broadcast-received flag.
  - All other bits = 0.
REQ-027 After the status word:
  - Transmit command: go to TX_DATA.
  - Otherwise: pulse msg_done and go to IDLE.
REQ-028 TX_DATA:
  - For n = 0 .. count-1: present buf_addr, take buf_rdata on the next cycle, pulse tx_dw when tx_busy == 0, then wait for tx_busy to rise and fall.
  - After the last word: pulse msg_done and return to IDLE.
REQ-029 A valid command received in any state other than IDLE aborts the current message and restarts decode with that command (superseding command).
REQ-030 The word index is 5 bits and wraps 31 -> 0 only at count 32; at most one tx_csw/tx_dw pulse is in flight at any time.

Reset
REQ-031 On reset_slow, within the same cycle:
  - State = IDLE.
  - tx_dword = 0, tx_csw = 0, tx_dw = 0, buf_we = 0, buf_addr = 0, buf_wdata = 0.
  - msg_done = 0, msg_err = 0, broadcast flag = 0, all counters = 0.
REQ-032 Reset asserted mid-message discards the message; no pulse is emitted after deassertion until a new command arrives.

Configuration
REQ-033 Macro RT_BROADCAST_EN defined:
  - A receive command to address 31 is accepted.
  - Its data is stored normally.
  - No status word is sent; msg_done pulses.
  - The broadcast flag is set and appears in the next status word, then clears.
REQ-034 Macro RT_BROADCAST_EN undefined: address 31 is treated as a non-matching address, and status bit 4 is always 0.

Verification
REQ-035 rt_addr = 5, receive command 0x2822 (SA1, 2 words), data 0x1234 and 0xABCD -> buffer writes at 0x020 and 0x021, then after RESP_GAP one tx_csw with tx_dword = 0x2800, then msg_done.
REQ-036 Transmit command 0x2C43 (SA2, 3 words), buffer preloaded with 0x0001..0x0003 -> tx_csw 0x2800, then three tx_dw pulses with tx_dword 0x0001, 0x0002, 0x0003, each issued only after tx_busy falls.
REQ-037 Receive command for 2 words, second data word with rx_perr = 1 -> msg_err = 1, no tx_csw, msg_done pulses; the next valid command yields status bit 10 = 0.
REQ-038 Command addressed to rt_addr 6 while rt_addr = 5 -> no buf_we, tx_csw or msg_done activity.
REQ-039 Receive command for 2 words, only 1 data word then silence -> after WORD_TIMEOUT cycles msg_err = 1, return to IDLE; reset asserted mid-TX_DATA -> all outputs 0 immediately.
REQ-040 With RT_BROADCAST_EN: command 0xF821 (address 31, SA1, 1 word) plus 1 data word -> buffer write, no status; a following transmit command returns status 0x2810.
